// File: rtl/uart_tx_frame_if.sv
// Word handshake between a source and the UART transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: tx_ready from the transmitter gates tx_valid from the source.
// Ports: tx_data (word), tx_valid (source has word), tx_ready (transmitter idle),
//        parity_odd (1 = odd parity for this word; only meaningful with parity builds).
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  parity_odd;

  modport master (
    output tx_data,
    output tx_valid,
    output parity_odd,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  parity_odd,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Latency: line drops to the start bit on the accept edge; frame is (1+DATA_WIDTH+P+STOP_BITS)*BIT_PERIOD clocks.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, not queued.
// Ports: sysclk, rstn (async active-low), tx_bus (slave handshake: tx_data/tx_valid/tx_ready/parity_odd),
//        uart_tx (registered serial line, idles high), tx_busy (not IDLE), tx_done (1-cycle frame-end pulse).
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1
) (
  input  logic             sysclk,
  input  logic             rstn,
  uart_tx_frame_if.slave   tx_bus,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CW         = $clog2(BIT_PERIOD);
  localparam int BW         = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_tx_frame: DATA_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (BIT_PERIOD < 2) begin : g_bad_baud
      $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  wrap;

`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = tx_bus.parity_odd;
`endif

  // End of the current bit period; the only point where the line may change.
  assign wrap = (cnt_q == CNT_MAX);

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Bit timer runs only inside a frame and wraps by explicit compare.
    if (state_q != IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_bus.tx_valid) begin
          shift_d = tx_bus.tx_data;
`ifdef UART_TX_PARITY_EN
          // Even parity is the XOR of the data; odd flips it.
          par_d   = (^tx_bus.tx_data) ^ tx_bus.parity_odd;
`endif
          tx_d    = 1'b0;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (wrap) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end

      DATA: begin
        if (wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // shift_q[1] is the bit that lands in position 0 after this shift.
            tx_d  = shift_q[1];
            bit_d = bit_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (wrap) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (wrap) begin
          if (stop_q == STOP_MAX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_bus.tx_ready = (state_q == IDLE);
  assign tx_busy         = (state_q != IDLE);
  assign uart_tx         = tx_q;
  assign tx_done         = done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter, successor to the fixed 8-bit/2-stop transmitter.
- Serialises one word per frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Uses a valid/ready handshake and latches the word at acceptance, so the upstream source may change data immediately.
- Sits between a byte/word source (FIFO, command engine) and the board TX pin.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLK_FREQ, 50_000_000, sysclk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. BIT_PERIOD = CLK_FREQ / BAUD_RATE (integer division) must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- tx_data  in  DATA_WIDTH  word to send; sampled only on the accept edge.
- tx_valid  in  1  source has a word.
- tx_ready  out  1  block can accept; equals (state == IDLE), combinational from state.
- parity_odd  in  1  1 = odd parity, 0 = even; sampled on the accept edge; ignored unless UART_TX_PARITY_EN.
- uart_tx  out  1  serial line, registered; idles high.
- tx_busy  out  1  high in any state other than IDLE.
- tx_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: the block enters IDLE immediately (asynchronous). uart_tx=1, tx_done=0, counters=0, shift register=0. tx_ready=1 and tx_busy=0 follow from IDLE.
- States: IDLE, START, DATA, PARITY (exists only with the macro), STOP.
- Accept: a rising edge with tx_valid && tx_ready. On that edge:
  - the shift register loads tx_data;
  - the parity bit is computed and latched;
  - uart_tx <= 0;
  - the state goes to START with the bit counter cleared.
- tx_valid while not IDLE is ignored. It is not queued.
- Bit timing: a cycle counter of $clog2(BIT_PERIOD) bits counts 0..BIT_PERIOD-1. Each bit holds uart_tx for exactly BIT_PERIOD clocks. uart_tx changes only on the edge where the counter wraps.
- START -> DATA on wrap; uart_tx <= shift[0].
- DATA: on each wrap, shift right and increment the bit index.
  - After bit DATA_WIDTH-1 wraps: go to PARITY, or to STOP if there is no parity.
  - On that transition, uart_tx <= parity bit or 1 respectively.
- PARITY -> STOP on wrap; uart_tx <= 1.
- STOP lasts STOP_BITS*BIT_PERIOD clocks, counted with a stop-bit index, not a widened counter.
- On the final wrap of STOP: the state goes to IDLE and tx_done is high for exactly the following cycle.
- Frame length, from the accept edge to the IDLE entry edge: (1 + DATA_WIDTH + P + STOP_BITS) * BIT_PERIOD clocks, where P = 1 with parity, else 0.
- Back-to-back: tx_ready rises in the same cycle tx_done is high. A held tx_valid is accepted on the next edge, so the minimum idle gap between the end of a stop bit and the next start bit is 1 clock.
- Reset mid-frame: the frame is aborted and uart_tx returns high asynchronously. No tx_done pulse is produced.
- tx_data changes after acceptance have no effect on the frame in flight.
- All counters wrap only via explicit compare. There is no free-running overflow.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is present.
  - The parity bit is the XOR of the latched data bits, inverted when parity_odd was 1 at accept. Odd parity makes the total count of ones in data+parity odd.
  - P = 1.
- Undefined:
  - There is no PARITY state and parity_odd is unused.
  - The frame is start + data + stop only, and P = 0.

Test Plan:
- Bench setup: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_PERIOD=10), DATA_WIDTH=8, STOP_BITS=1, no macro.
- Basic frame: send 0xA5. Line = 0 for 10 clocks, then 1,0,1,0,0,1,0,1 at 10 clocks each, then 1 for 10 clocks. tx_done pulses exactly 100 clocks after the accept edge. tx_ready=0 throughout the frame.
- Back-to-back: tx_valid held high with 0x00 then 0xFF. The second start bit begins 101 clocks after the first accept. tx_done pulses twice, 101 clocks apart.
- Parity (UART_TX_PARITY_EN, DATA_WIDTH=7, STOP_BITS=2): send 0x41.
  - parity_odd=0: parity bit = 0.
  - parity_odd=1: parity bit = 1.
  - Frame = 110 clocks.
- Data hold: change tx_data to 0x3C one cycle after accepting 0x81. Serialised bits remain 0x81. tx_valid pulses while busy are not accepted and produce no extra frame.
- Reset mid-frame: deassert rstn at clock 35 of a frame. uart_tx=1, tx_busy=0, tx_ready=1 and tx_done=0 immediately, without waiting for a clock. After release, a new 0x5A frame transmits correctly.
- Width sweep: DATA_WIDTH=5 and 9 with STOP_BITS=2. Frame lengths are 80 and 120 clocks, LSB first, and tx_done lands on those counts.
